// File: rtl/dino_pkg.sv
// Constants shared by the dino player blocks: player state encoding and
// the meaning of each game_tick strobe bit.
package dino_pkg;

  typedef enum logic [1:0] {
    PS_RUN  = 2'd0,
    PS_JUMP = 2'd1,
    PS_DUCK = 2'd2,
    PS_DEAD = 2'd3
  } player_state_t;

  // game_tick[TICK_VEL] strobes velocity updates, game_tick[TICK_POS] position updates
  localparam int TICK_VEL = 0;
  localparam int TICK_POS = 1;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, stability counter and rising-edge detect for one
// pushbutton. The debounced level only changes after DEBOUNCE_CYCLES
// consecutive synchronized samples disagree with it.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync0;
  logic          sync1;
  logic          level_d;
  logic [CW-1:0] cnt;

  // Synchronize the raw input, then flip the level once it has disagreed long enough
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync0   <= 1'b0;
      sync1   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
    end else begin
      sync0   <= raw;
      sync1   <= sync0;
      level_d <= level;
      if (sync1 != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync1;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign rise = level & ~level_d;

endmodule

// File: rtl/player_input_ctrl.sv
// Turns raw jump/duck buttons into tick-aligned controls for player_physics,
// tracks the dino's logical state, drives the run-cycle frame bit and
// raises a one-cycle restart request when jump is pressed after death.
module player_input_ctrl
  import dino_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int ANIM_TICKS      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up_raw,
  input  logic       btn_down_raw,
  input  logic [1:0] game_tick,
  input  logic       jump_done,
  input  logic       game_over,
  output logic       jump_pulse,
  output logic       button_down,
  output logic [1:0] player_state,
  output logic       anim_frame,
  output logic       restart
);

  localparam int AW = (ANIM_TICKS > 1) ? $clog2(ANIM_TICKS) : 1;
  localparam logic [AW-1:0] ANIM_LAST = AW'(ANIM_TICKS - 1);

  logic          up_db;
  logic          up_rise;
  logic          down_db;
  logic          down_rise_unused;
  logic          jump_req;
  logic [AW-1:0] anim_cnt;
  player_state_t state;
  player_state_t state_next;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_up_raw),
    .level (up_db),
    .rise  (up_rise)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_down_raw),
    .level (down_db),
    .rise  (down_rise_unused)
  );

  // Jump fires only on the velocity strobe so physics sees it on the same cycle
  assign jump_pulse   = jump_req & game_tick[TICK_VEL] & (state == PS_RUN) & ~game_over;
  assign button_down  = down_db & (state != PS_DEAD);
  assign restart      = up_rise & (state == PS_DEAD);
  assign player_state = state;

  // Hold a jump request from the press until the next velocity strobe; no buffering outside RUN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      jump_req <= 1'b0;
    end else if (jump_pulse || down_db || (state != PS_RUN)) begin
      jump_req <= 1'b0;
    end else if (up_rise && !game_over) begin
      jump_req <= 1'b1;
    end
  end

  // Player state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= PS_RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; collision overrides everything
  always_comb begin
    state_next = state;
    if (game_over) begin
      state_next = PS_DEAD;
    end else begin
      case (state)
        PS_RUN: begin
          if (jump_pulse)   state_next = PS_JUMP;
          else if (down_db) state_next = PS_DUCK;
        end
        PS_JUMP: begin
          if (game_tick[TICK_POS] && jump_done) state_next = PS_RUN;
        end
        PS_DUCK: begin
          if (!down_db) state_next = PS_RUN;
        end
        PS_DEAD: begin
          state_next = PS_RUN;
        end
        default: state_next = PS_RUN;
      endcase
    end
  end

  // Run-cycle animation: advances on position strobes while on the ground, resets on death
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      anim_cnt   <= '0;
      anim_frame <= 1'b0;
    end else if ((state_next == PS_DEAD) && (state != PS_DEAD)) begin
      anim_cnt   <= '0;
      anim_frame <= 1'b0;
    end else if (game_tick[TICK_POS] && ((state == PS_RUN) || (state == PS_DUCK))) begin
      if (anim_cnt == ANIM_LAST) begin
        anim_cnt   <= '0;
        anim_frame <= ~anim_frame;
      end else begin
        anim_cnt <= anim_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_player_input_ctrl.sv
// Directed bench for player_input_ctrl: a table of timed input phases with
// hand-computed expected outputs, plus hand-written sequences for debounce
// latency, glitch rejection and mid-operation reset.
module tb_player_input_ctrl;

  logic       clk;
  logic       rst_n;
  logic       btn_up_raw;
  logic       btn_down_raw;
  logic [1:0] game_tick;
  logic       jump_done;
  logic       game_over;
  logic       jump_pulse;
  logic       button_down;
  logic [1:0] player_state;
  logic       anim_frame;
  logic       restart;

  int n_vec;
  int n_bad;

  typedef struct {
    logic       up;
    logic       down;
    logic [1:0] tick;
    logic       jd;
    logic       go;
    int         cycles;
    logic       e_pulse;
    logic       e_bd;
    logic [1:0] e_state;
    logic       e_frame;
    logic       e_restart;
  } vec_t;

  vec_t vecs[$];

  player_input_ctrl #(.DEBOUNCE_CYCLES(16), .ANIM_TICKS(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_up_raw   (btn_up_raw),
    .btn_down_raw (btn_down_raw),
    .game_tick    (game_tick),
    .jump_done    (jump_done),
    .game_over    (game_over),
    .jump_pulse   (jump_pulse),
    .button_down  (button_down),
    .player_state (player_state),
    .anim_frame   (anim_frame),
    .restart      (restart)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic ep, input logic eb,
                           input logic [1:0] es, input logic ef, input logic er);
    check({tag, "_jump_pulse"},   {1'b0, jump_pulse},  {1'b0, ep});
    check({tag, "_button_down"},  {1'b0, button_down}, {1'b0, eb});
    check({tag, "_player_state"}, player_state,        es);
    check({tag, "_anim_frame"},   {1'b0, anim_frame},  {1'b0, ef});
    check({tag, "_restart"},      {1'b0, restart},     {1'b0, er});
  endtask

  task automatic add(input logic up, input logic down, input logic [1:0] tk,
                     input logic jd, input logic go, input int cyc,
                     input logic ep, input logic eb, input logic [1:0] es,
                     input logic ef, input logic er);
    vec_t v;
    v.up = up; v.down = down; v.tick = tk; v.jd = jd; v.go = go; v.cycles = cyc;
    v.e_pulse = ep; v.e_bd = eb; v.e_state = es; v.e_frame = ef; v.e_restart = er;
    vecs.push_back(v);
  endtask

  initial begin
    logic seen;
    n_vec = 0;
    n_bad = 0;
    rst_n        = 1'b0;
    btn_up_raw   = 1'b0;
    btn_down_raw = 1'b0;
    game_tick    = 2'b00;
    jump_done    = 1'b0;
    game_over    = 1'b0;

    // Table starts with the dino in JUMP right after the first jump, up still held
    //   up down tick  jd go cyc   pulse bd state frame restart
    add(0, 0, 2'b00, 0, 0, 20,  0, 0, 2'd1, 0, 0);  // release up mid-air
    add(0, 0, 2'b10, 0, 0, 1,   0, 0, 2'd1, 0, 0);  // position tick, not landed
    add(0, 0, 2'b00, 0, 0, 1,   0, 0, 2'd1, 0, 0);
    add(0, 0, 2'b10, 0, 0, 1,   0, 0, 2'd1, 0, 0);
    add(0, 0, 2'b00, 0, 0, 1,   0, 0, 2'd1, 0, 0);
    add(0, 0, 2'b10, 0, 0, 1,   0, 0, 2'd1, 0, 0);
    add(0, 0, 2'b00, 0, 0, 1,   0, 0, 2'd1, 0, 0);
    add(1, 0, 2'b00, 0, 0, 20,  0, 0, 2'd1, 0, 0);  // up press while airborne is dropped
    add(1, 0, 2'b10, 1, 0, 1,   0, 0, 2'd0, 0, 0);  // landing
    add(1, 0, 2'b01, 0, 0, 3,   0, 0, 2'd0, 0, 0);  // no buffered jump
    add(0, 0, 2'b00, 0, 0, 20,  0, 0, 2'd0, 0, 0);
    add(0, 1, 2'b00, 0, 0, 20,  0, 1, 2'd2, 0, 0);  // duck in RUN
    add(0, 0, 2'b00, 0, 0, 20,  0, 0, 2'd0, 0, 0);  // release duck
    add(1, 0, 2'b00, 0, 0, 20,  0, 0, 2'd0, 0, 0);  // press up, request pending
    add(1, 0, 2'b01, 0, 0, 0,   1, 0, 2'd0, 0, 0);  // pulse with velocity strobe
    add(1, 0, 2'b01, 0, 0, 1,   0, 0, 2'd1, 0, 0);  // now JUMP
    add(0, 1, 2'b00, 0, 0, 20,  0, 1, 2'd1, 0, 0);  // duck mid-air stays JUMP
    add(0, 1, 2'b10, 1, 0, 1,   0, 1, 2'd0, 0, 0);  // land into RUN
    add(0, 1, 2'b00, 0, 0, 1,   0, 1, 2'd2, 0, 0);  // then DUCK
    add(0, 1, 2'b10, 0, 0, 3,   0, 1, 2'd2, 0, 0);  // 3 anim ticks in DUCK
    add(0, 1, 2'b10, 0, 0, 1,   0, 1, 2'd2, 1, 0);  // 4th toggles frame
    add(0, 1, 2'b00, 0, 0, 1,   0, 1, 2'd2, 1, 0);
    add(0, 0, 2'b00, 0, 0, 20,  0, 0, 2'd0, 1, 0);
    add(0, 0, 2'b10, 0, 0, 4,   0, 0, 2'd0, 0, 0);  // RUN: toggle back
    add(0, 0, 2'b10, 0, 0, 4,   0, 0, 2'd0, 1, 0);  // toggle again
    add(0, 0, 2'b10, 0, 0, 2,   0, 0, 2'd0, 1, 0);  // counter part-way
    add(0, 0, 2'b00, 0, 1, 1,   0, 0, 2'd3, 0, 0);  // collision: DEAD, anim cleared
    add(0, 1, 2'b00, 0, 1, 20,  0, 0, 2'd3, 0, 0);  // duck masked while dead
    add(1, 1, 2'b00, 0, 1, 18,  0, 0, 2'd3, 0, 1);  // up edge -> restart
    add(1, 1, 2'b00, 0, 1, 1,   0, 0, 2'd3, 0, 0);  // restart lasts one cycle
    add(1, 1, 2'b10, 0, 1, 3,   0, 0, 2'd3, 0, 0);  // anim held while dead
    add(0, 0, 2'b00, 0, 0, 1,   0, 1, 2'd0, 0, 0);  // revive into RUN, duck still debounced
    add(0, 0, 2'b00, 0, 0, 1,   0, 1, 2'd2, 0, 0);
    add(0, 0, 2'b00, 0, 0, 20,  0, 0, 2'd0, 0, 0);
    add(0, 0, 2'b10, 0, 0, 3,   0, 0, 2'd0, 0, 0);  // counter restarted from 0
    add(0, 0, 2'b10, 0, 0, 1,   0, 0, 2'd0, 1, 0);

    // Reset values
    step(3);
    check_all("reset", 0, 0, 2'd0, 0, 0);
    rst_n = 1'b1;

    // 10-cycle glitch must not reach the debounced level
    game_tick = 2'b01;
    btn_up_raw = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 35; i++) begin
      if (i == 10) btn_up_raw = 1'b0;
      step(1);
      if (jump_pulse !== 1'b0 || player_state !== 2'd0) seen = 1'b1;
    end
    check("glitch_no_effect", {1'b0, seen}, 2'd0);

    // Clean press: level after 18 edges, request latched at 19, pulse with tick[0]
    btn_up_raw = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      step(1);
      check($sformatf("press_edge%0d_jump_pulse", k), {1'b0, jump_pulse}, {1'b0, (k == 19)});
    end
    step(1);
    check("after_pulse_state", player_state, 2'd1);
    check("after_pulse_jump_pulse", {1'b0, jump_pulse}, 2'd0);
    game_tick = 2'b00;

    foreach (vecs[i]) begin
      btn_up_raw   = vecs[i].up;
      btn_down_raw = vecs[i].down;
      game_tick    = vecs[i].tick;
      jump_done    = vecs[i].jd;
      game_over    = vecs[i].go;
      if (vecs[i].cycles == 0) #1;
      else step(vecs[i].cycles);
      check_all($sformatf("vec%0d", i), vecs[i].e_pulse, vecs[i].e_bd,
                vecs[i].e_state, vecs[i].e_frame, vecs[i].e_restart);
    end

    // Mid-operation reset drops a pending jump request and the debounce progress
    btn_up_raw   = 1'b1;
    btn_down_raw = 1'b0;
    game_tick    = 2'b00;
    jump_done    = 1'b0;
    game_over    = 1'b0;
    step(19);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    check_all("midreset", 0, 0, 2'd0, 0, 0);
    game_tick = 2'b01;
    for (int k = 1; k <= 19; k++) begin
      step(1);
      check($sformatf("repress_edge%0d_jump_pulse", k), {1'b0, jump_pulse}, {1'b0, (k == 19)});
    end
    game_tick  = 2'b00;
    btn_up_raw = 1'b0;
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
